instr_mem_loader: RTL and testbench

Parametrised instruction memory for the 16-bit CPU with a runtime program-load port, replacing the fixed reset-time program image.
- Programs are streamed in word-by-word through a valid/ready load handshake.
- The fetch stage then reads instructions through a registered request/valid fetch port using byte addresses (PC steps by 2).
- Unloaded or out-of-range locations return a fill word (the HALT encoding by default), so the CPU never executes uninitialised storage.

---
 rtl/instr_mem_if.sv | 43 ++++
 rtl/instr_mem_loader.sv | 149 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_if.sv
// Load and fetch bus of the runtime-loadable instruction memory.
// With INSTR_MEM_FAULT_EN defined the bus also carries fetch_fault.
interface instr_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 6
);
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [CNT_W-1:0]  word_count;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] instruction;
    logic              running;
`ifdef INSTR_MEM_FAULT_EN
    logic              fetch_fault;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, load_done, word_count, fetch_valid, instruction, running,
               fetch_fault
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, load_done, word_count, fetch_valid, instruction, running,
               fetch_fault
    );
`else
    modport master (
        output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        input  load_ready, load_done, word_count, fetch_valid, instruction, running
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
        output load_ready, load_done, word_count, fetch_valid, instruction, running
    );
`endif
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loaded at runtime over a valid/ready stream, read by a registered fetch port.
// Optional INSTR_MEM_FAULT_EN flags misaligned or unloaded fetches on fetch_fault.
//
// state   | meaning
// IDLE    | no program; waiting for load_start
// LOAD    | accepting program words into storage
// RUN     | program valid; serving fetches
module instr_mem_loader #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 32,
    parameter int                ADDR_W    = 16,
    parameter logic [DATA_W-1:0] FILL_WORD = 16'hEBCF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    instr_mem_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              fvalid_q, fvalid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic              fetch_acc;
    logic [ADDR_W-2:0] index;
    logic              in_range;
    logic              hit;

    assign index    = bus.fetch_addr[ADDR_W-1:1];
    // word_count never exceeds DEPTH, so this also rejects indices beyond the array
    assign in_range = {1'b0, index} < ADDR_W'(count_q);

`ifdef INSTR_MEM_FAULT_EN
    logic fault_q, fault_d;

    assign hit     = in_range && !bus.fetch_addr[0];
    assign fault_d = fetch_acc && !hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.fetch_fault = fault_q;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = bus.fetch_addr[0];
    assign hit             = in_range;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        fetch_acc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (bus.load_valid) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    if (bus.load_last || ptr_q == PTR_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // a reload request takes priority and drops a coincident fetch
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end else if (bus.fetch_req) begin
                    fetch_acc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fvalid_d = fetch_acc;
        instr_d  = instr_q;
        if (fetch_acc) begin
            instr_d = hit ? mem_q[index[PTR_W-1:0]] : FILL_WORD;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            fvalid_q <= 1'b0;
            instr_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            fvalid_q <= fvalid_d;
            instr_q  <= instr_d;
        end
    end

    // storage is not cleared on reset; word_count masks stale contents
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[ptr_q] <= bus.load_data;
        end
    end

    assign bus.load_ready  = (state_q == ST_LOAD);
    assign bus.running     = (state_q == ST_RUN);
    assign bus.load_done   = done_q;
    assign bus.word_count  = count_q;
    assign bus.fetch_valid = fvalid_q;
    assign bus.instruction = instr_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed program-load scenarios followed by random traffic,
// every cycle compared against a word-array model of the load/fetch rules.
module tb_instr_mem_loader;
    localparam int          DATA_W = 16;
    localparam int          DEPTH  = 32;
    localparam int          ADDR_W = 16;
    localparam int          CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [15:0] FILL   = 16'hEBCF;
    localparam int          M_IDLE = 0;
    localparam int          M_LOAD = 1;
    localparam int          M_RUN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    instr_mem_loader #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL_WORD(FILL)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          mode   = M_IDLE;
    int          cnt    = 0;
    logic [15:0] mmem [DEPTH];
    logic [15:0] exp_instr = '0;
    logic        exp_fv    = 1'b0;
    logic        exp_done  = 1'b0;
    logic        exp_fault = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs now on the bus, then compare all outputs.
    task automatic tick();
        int idx;
        exp_done  = 1'b0;
        exp_fv    = 1'b0;
        exp_fault = 1'b0;
        if (rst) begin
            mode      = M_IDLE;
            cnt       = 0;
            exp_instr = '0;
        end else if (mode == M_IDLE) begin
            if (bus.load_start) begin
                mode = M_LOAD;
                cnt  = 0;
            end
        end else if (mode == M_LOAD) begin
            if (bus.load_valid) begin
                mmem[cnt] = bus.load_data;
                cnt++;
                if (bus.load_last || cnt == DEPTH) begin
                    mode     = M_RUN;
                    exp_done = 1'b1;
                end
            end
        end else begin
            if (bus.load_start) begin
                mode = M_LOAD;
                cnt  = 0;
            end else if (bus.fetch_req) begin
                idx    = int'(bus.fetch_addr) / 2;
                exp_fv = 1'b1;
`ifdef INSTR_MEM_FAULT_EN
                exp_fault = bus.fetch_addr[0] || idx >= cnt;
                exp_instr = exp_fault ? FILL : mmem[idx];
`else
                exp_instr = (idx < cnt) ? mmem[idx] : FILL;
`endif
            end
        end
        @(posedge clk);
        #1;
        check("load_ready",  32'(bus.load_ready),  32'(mode == M_LOAD));
        check("running",     32'(bus.running),     32'(mode == M_RUN));
        check("load_done",   32'(bus.load_done),   32'(exp_done));
        check("word_count",  32'(bus.word_count),  32'(cnt));
        check("fetch_valid", 32'(bus.fetch_valid), 32'(exp_fv));
        check("instruction", 32'(bus.instruction), 32'(exp_instr));
`ifdef INSTR_MEM_FAULT_EN
        check("fetch_fault", 32'(bus.fetch_fault), 32'(exp_fault));
`endif
    endtask

    task automatic drive(input logic st, input logic v, input logic [15:0] d, input logic last,
                         input logic rq, input logic [15:0] a);
        bus.load_start = st;
        bus.load_valid = v;
        bus.load_data  = d;
        bus.load_last  = last;
        bus.fetch_req  = rq;
        bus.fetch_addr = a;
        tick();
    endtask

    initial begin
        logic [15:0] prog [4];
        logic [15:0] addrs [6];
        prog[0] = 16'h012F; prog[1] = 16'h012E; prog[2] = 16'h034C; prog[3] = 16'h0561;
        addrs[0] = 16'h00; addrs[1] = 16'h02; addrs[2] = 16'h04;
        addrs[3] = 16'h06; addrs[4] = 16'h08; addrs[5] = 16'h40;

        bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_data = '0;
        bus.load_last  = 1'b0; bus.fetch_req  = 1'b0; bus.fetch_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // four-word program terminated by load_last
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, prog[i], i == 3, 1'b0, '0);
        check("tp_count4", 32'(bus.word_count), 32'd4);
        check("tp_done",   32'(bus.load_done),  32'd1);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        check("tp_done_once", 32'(bus.load_done), 32'd0);

        // back-to-back fetches, including index == word_count and index >= DEPTH
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0, 1'b1, addrs[i]);
            check("tp_fetch", 32'(bus.instruction), 32'((i < 4) ? prog[i] : FILL));
        end
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

        // misaligned fetch behaviour depends on the optional fault feature
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h0003);
`ifdef INSTR_MEM_FAULT_EN
        check("tp_misalign", 32'(bus.instruction), 32'(FILL));
`else
        check("tp_misalign", 32'(bus.instruction), 32'(prog[1]));
`endif

        // full-depth load without load_last, then a 33rd word that must be refused
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0, '0);
        check("tp_count32", 32'(bus.word_count), 32'(DEPTH));
        drive(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, '0);
        check("tp_ready33", 32'(bus.load_ready), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'(2 * (DEPTH - 1)));

        // load_start beats a coincident fetch; fetches during reload are ignored
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
        check("tp_collide_fv",  32'(bus.fetch_valid), 32'd0);
        check("tp_collide_cnt", 32'(bus.word_count),  32'd0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'($urandom), i == 2, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'h0004);

        // reset in the middle of a load
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, prog[i], 1'b0, 1'b0, '0);
        rst = 1'b1;
        drive(1'b0, 1'b1, prog[2], 1'b0, 1'b0, '0);
        rst = 1'b0;
        check("tp_rst_cnt",   32'(bus.word_count),  32'd0);
        check("tp_rst_instr", 32'(bus.instruction), 32'd0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
        check("tp_rst_fetch", 32'(bus.fetch_valid), 32'd0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            drive($urandom_range(0, 24) == 0,
                  $urandom_range(0, 9) < 7,
                  16'($urandom),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 6,
                  16'($urandom_range(0, 16'h4F)));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
